// File: rtl/rr_seqdet_sched_pkg.sv
// Shared definitions for the round-robin sequence-detector scheduler:
// frame FSM state encoding, default parameter values and width helpers.
package rr_seqdet_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   localparam int                N_DEF         = 4;
   localparam int                FRAME_LEN_DEF = 8;
   localparam int                PAT_LEN_DEF   = 4;
   localparam logic [3:0]        PATTERN_DEF   = 4'b1101;
   localparam int                CNT_W_DEF     = 4;

   // Width needed to index n items; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_seqdet_sched_seq_det_core.sv
// Serial pattern detector: keeps the last PAT_LEN-1 accepted bits and flags
// a match when those bits followed by the current bit equal PATTERN.
// A fill counter blocks matches until enough bits have arrived since clr.
module seq_det_core
   import rr_seqdet_sched_pkg::*;
#(
   parameter int                 PAT_LEN = PAT_LEN_DEF,
   parameter logic [PAT_LEN-1:0] PATTERN = PATTERN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic bit_in,
   output logic match
);

   localparam int                HIST_W = PAT_LEN - 1;
   localparam int                FILL_W = id_width(PAT_LEN);
   localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN - 1);

   logic [HIST_W-1:0] hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;

   // Shift accepted bits into history; fill count saturates once a full window exists.
   always_comb begin
      // NOTE: every comb output gets a default first, so no path can infer a latch.
      hist_d = hist_q;
      fill_d = fill_q;
      if (clr) begin
         hist_d = '0;
         fill_d = '0;
      end else if (en) begin
         hist_d = HIST_W'({hist_q, bit_in});
         if (fill_q != FULL) begin
            fill_d = fill_q + FILL_W'(1);
         end
      end
   end

   // History and fill registers.
   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignments so every flop sees pre-edge values.
      if (rst) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

   // Mealy match: the bit being accepted right now completes the pattern.
   always_comb begin
      match = en && (fill_q == FULL) && ({hist_q, bit_in} == PATTERN);
   end

endmodule

// File: rtl/rr_seqdet_sched.sv
// Round-robin scheduler time-sharing one sequence detector among N lanes.
// IDLE arbitrates, RUN streams one lane's bits for a frame, DONE reports
// the frame result for one cycle and always returns to IDLE.
module rr_seqdet_sched
   import rr_seqdet_sched_pkg::*;
#(
   parameter int                 N         = N_DEF,
   parameter int                 FRAME_LEN = FRAME_LEN_DEF,
   parameter int                 PAT_LEN   = PAT_LEN_DEF,
   parameter logic [PAT_LEN-1:0] PATTERN   = PATTERN_DEF,
   parameter int                 CNT_W     = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N-1:0]             req,
   input  logic [N-1:0]             x_bus,
   output logic [N-1:0]             gnt,
   output logic                     busy,
   output logic                     match,
   output logic                     done,
   output logic                     aborted,
   output logic [id_width(N)-1:0]   done_id,
   output logic [CNT_W-1:0]         match_cnt
);

   localparam int               ID_W     = id_width(N);
   localparam int               IDX_W    = id_width(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              aborted_q, aborted_d;

   logic              sample_en;
   logic              sample_bit;
   logic              last_bit;
   logic              det_clr;
   logic              det_match;
   logic [ID_W-1:0]   winner;

   // First requesting lane at or after p, wrapping modulo N.
   function automatic logic [ID_W-1:0] rr_pick(input logic [N-1:0] r,
                                               input logic [ID_W-1:0] p);
      logic [ID_W-1:0] pick;
      logic            found;
      logic [N-1:0]    sh;
      int              cand;
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         cand = (int'(p) + i) % N;
         sh   = r >> cand;
         if (!found && sh[0]) begin
            pick  = ID_W'(cand);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign winner     = rr_pick(req, ptr_q);
   assign sample_en  = (state_q == S_RUN) && req[id_q];
   assign sample_bit = x_bus[id_q];
   assign last_bit   = (idx_q == LAST_IDX);

   seq_det_core #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN)
   ) u_det (
      .clk    (clk),
      .rst    (rst),
      .clr    (det_clr),
      .en     (sample_en),
      .bit_in (sample_bit),
      .match  (det_match)
   );

   // State register plus frame bookkeeping flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         id_q      <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         id_q      <= id_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         aborted_q <= aborted_d;
      end
   end

   // Next state: grant on any request, leave RUN on last bit or dropped request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (|req) state_d = S_RUN;
         S_RUN:   if (!sample_en || last_bit) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Grant latch, pointer advance, bit index and match counting.
   always_comb begin
      ptr_d     = ptr_q;
      id_d      = id_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      aborted_d = aborted_q;
      det_clr   = 1'b0;
      if (state_q == S_IDLE && |req) begin
         id_d      = winner;
         ptr_d     = (winner == ID_W'(N - 1)) ? '0 : winner + ID_W'(1);
         idx_d     = '0;
         cnt_d     = '0;
         aborted_d = 1'b0;
         det_clr   = 1'b1;
      end else if (state_q == S_RUN) begin
         if (sample_en) begin
            idx_d     = idx_q + IDX_W'(1);
            aborted_d = 1'b0;
            if (det_match) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            aborted_d = 1'b1;
         end
      end
   end

   // Outputs decoded from state; result fields only shown during DONE.
   always_comb begin
      gnt = '0;
      for (int i = 0; i < N; i++) begin
         gnt[i] = (state_q == S_RUN) && (id_q == ID_W'(i));
      end
      busy      = (state_q != S_IDLE);
      match     = det_match;
      done      = (state_q == S_DONE);
      aborted   = (state_q == S_DONE) ? aborted_q : 1'b0;
      done_id   = (state_q == S_DONE) ? id_q : '0;
      match_cnt = cnt_q;
   end

endmodule

// File: tb/tb_rr_seqdet_sched.sv
// Bench for rr_seqdet_sched: frame-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rr_seqdet_sched;

   localparam int         N         = 4;
   localparam int         FRAME_LEN = 8;
   localparam int         PAT_LEN   = 4;
   localparam logic [3:0] PATTERN   = 4'b1101;
   localparam int         CNT_W     = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  x_bus = '0;
   logic [N-1:0]  gnt;
   logic          busy, match, done, aborted;
   logic [1:0]    done_id;
   logic [CNT_W-1:0] match_cnt;

   int n_checks = 0;
   int n_errors = 0;

   rr_seqdet_sched #(
      .N(N), .FRAME_LEN(FRAME_LEN), .PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .x_bus(x_bus), .gnt(gnt), .busy(busy),
      .match(match), .done(done), .aborted(aborted), .done_id(done_id), .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_RUN, M_DONE} mphase_e;
   mphase_e   ph = M_IDLE;
   int        m_ptr = 0, m_id = 0, m_cnt = 0;
   logic      m_ab = 1'b0;
   logic      m_bits[$];
   logic [N-1:0] e_gnt;
   logic      e_match;

   // Does bit x complete PATTERN given the bits already accepted this frame?
   function automatic logic hit(input logic x);
      logic [PAT_LEN-1:0] w;
      if (m_bits.size() < PAT_LEN - 1) return 1'b0;
      w = '0;
      for (int j = m_bits.size() - (PAT_LEN - 1); j < m_bits.size(); j++)
         w = {w[PAT_LEN-2:0], m_bits[j]};
      w = {w[PAT_LEN-2:0], x};
      return w == PATTERN;
   endfunction

   initial begin : scoreboard
      @(posedge clk);
      forever begin
         @(negedge clk);
         #2;
         e_gnt = '0;
         if (ph == M_RUN) e_gnt[m_id] = 1'b1;
         e_match = (ph == M_RUN) && req[m_id] && hit(x_bus[m_id]);
         check("sb_gnt", gnt, e_gnt);
         check("sb_gnt_onehot0", $onehot0(gnt), 1);
         check("sb_busy", busy, ph != M_IDLE);
         check("sb_match", match, e_match);
         check("sb_done", done, ph == M_DONE);
         check("sb_aborted", aborted, (ph == M_DONE) ? m_ab : 1'b0);
         check("sb_done_id", done_id, (ph == M_DONE) ? m_id : 0);
         check("sb_match_cnt", match_cnt, m_cnt);
         // advance to the state the coming clock edge produces
         if (rst) begin
            ph = M_IDLE; m_ptr = 0; m_id = 0; m_cnt = 0; m_ab = 1'b0;
            m_bits.delete();
         end else begin
            case (ph)
               M_IDLE: if (req != '0) begin
                  for (int k = 0; k < N; k++) begin
                     if (req[(m_ptr + k) % N]) begin
                        m_id = (m_ptr + k) % N;
                        break;
                     end
                  end
                  m_ptr = (m_id + 1) % N;
                  m_cnt = 0;
                  m_bits.delete();
                  ph = M_RUN;
               end
               M_RUN: begin
                  if (req[m_id]) begin
                     if (e_match) m_cnt++;
                     m_bits.push_back(x_bus[m_id]);
                     if (m_bits.size() == FRAME_LEN) begin
                        ph = M_DONE; m_ab = 1'b0;
                     end
                  end else begin
                     ph = M_DONE; m_ab = 1'b1;
                  end
               end
               default: ph = M_IDLE;
            endcase
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] xv);
      @(negedge clk);
      rst = r; req = rq; x_bus = xv;
      #3;
   endtask

   // Stream nbits of data (MSB first) on lane; optionally pin match per bit index.
   task automatic frame_bits(input int lane, input logic [N-1:0] rq, input logic [7:0] data,
                             input int nbits, input logic [7:0] exp_mask, input logic chk_mask);
      logic [N-1:0] xv, eg;
      for (int i = 0; i < nbits; i++) begin
         xv = '0; xv[lane] = data[7-i];
         eg = '0; eg[lane] = 1'b1;
         step(1'b0, rq, xv);
         check("lit_gnt", gnt, eg);
         if (i == 0) check("lit_cnt_cleared_at_grant", match_cnt, 0);
         if (chk_mask) check("lit_match_bit", match, exp_mask[i]);
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int           rr_order [3] = '{1, 3, 1};
   logic [7:0]   rr_data  [3] = '{8'b11011010, 8'b00110111, 8'b11101101};

   initial begin : stimulus
      // reset state
      step(1'b0, 4'b0001, 4'b0000);
      check("rst_gnt", gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", match_cnt, 0);
      check("rst_done", done, 0);

      // basic match: lane0 bits 1,1,0,1,1,0,1,0 -> matches at indices 3 and 6
      frame_bits(0, 4'b0001, 8'b11011010, 8, 8'b0100_1000, 1'b1);
      step(1'b0, 4'b0000, 4'b0000);
      check("basic_done", done, 1);
      check("basic_done_id", done_id, 0);
      check("basic_cnt", match_cnt, 2);
      check("basic_aborted", aborted, 0);
      check("basic_done_gnt", gnt, 0);

      // round robin: req=1010 from reset -> lanes 1,3,1
      step(1'b1, 4'b1010, 4'b0000);
      for (int f = 0; f < 3; f++) begin
         step(1'b0, 4'b1010, 4'b0000);
         check("rr_idle_gnt", gnt, 0);
         frame_bits(rr_order[f], 4'b1010, rr_data[f], 8, 8'h00, 1'b0);
         step(1'b0, 4'b1010, 4'b0000);
         check("rr_done", done, 1);
         check("rr_done_id", done_id, rr_order[f]);
      end

      // abort: lane2 bits 1,1,0,1 then req drops at index 4
      step(1'b1, 4'b0100, 4'b0000);
      step(1'b0, 4'b0100, 4'b0000);
      frame_bits(2, 4'b0100, 8'b11010000, 4, 8'b0000_1000, 1'b1);
      step(1'b0, 4'b0000, 4'b0100);
      check("abort_match", match, 0);
      check("abort_gnt", gnt, 4'b0100);
      step(1'b0, 4'b0000, 4'b0000);
      check("abort_aborted", aborted, 1);
      check("abort_cnt", match_cnt, 1);
      check("abort_done_id", done_id, 2);
      // pointer now at 3: all lanes requesting picks lane3
      step(1'b0, 4'b1111, 4'b0000);
      step(1'b0, 4'b0000, 4'b0000);
      check("ptr_after_abort", gnt, 4'b1000);
      step(1'b0, 4'b0000, 4'b0000);
      check("abort2_aborted", aborted, 1);
      check("abort2_done_id", done_id, 3);

      // cross-frame isolation on lane0
      step(1'b1, 4'b0001, 4'b0000);
      step(1'b0, 4'b0001, 4'b0000);
      frame_bits(0, 4'b0001, 8'b11010110, 8, 8'b0000_1000, 1'b1);
      step(1'b0, 4'b0001, 4'b0000);
      check("iso_a_cnt", match_cnt, 1);
      step(1'b0, 4'b0001, 4'b0000);
      check("iso_hold_cnt", match_cnt, 1);
      frame_bits(0, 4'b0001, 8'b10110100, 8, 8'b0010_0000, 1'b1);
      step(1'b0, 4'b0000, 4'b0000);
      check("iso_b_cnt", match_cnt, 1);
      check("iso_b_aborted", aborted, 0);

      // reset mid-frame at bit index 5 of a lane1 frame
      step(1'b1, 4'b0010, 4'b0000);
      step(1'b0, 4'b0010, 4'b0000);
      frame_bits(1, 4'b0010, 8'b11011000, 5, 8'b0000_1000, 1'b1);
      check("midrst_cnt_before", match_cnt, 1);
      step(1'b1, 4'b1111, 4'b0000);
      step(1'b0, 4'b1111, 4'b0000);
      check("midrst_gnt", gnt, 0);
      check("midrst_busy", busy, 0);
      check("midrst_cnt", match_cnt, 0);
      frame_bits(0, 4'b1111, 8'h00, 8, 8'h00, 1'b1);
      step(1'b0, 4'b0000, 4'b0000);
      check("midrst_done_id", done_id, 0);

      // no-match frame on lane3 (pointer at 1, only lane3 requests)
      step(1'b0, 4'b1000, 4'b0000);
      frame_bits(3, 4'b1000, 8'h00, 8, 8'h00, 1'b1);
      step(1'b0, 4'b0000, 4'b0000);
      check("nomatch_cnt", match_cnt, 0);
      check("nomatch_aborted", aborted, 0);
      check("nomatch_done_id", done_id, 3);

      step(1'b0, 4'b0000, 4'b0000);
      step(1'b0, 4'b0000, 4'b0000);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
